// File: rtl/ir_fetch_decode_pkg.sv
// ir_fetch_decode_pkg: opcode constants, FSM state encoding and IR field positions
package ir_fetch_decode_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_ANDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int RT_LSB  = 0;
  localparam int IMM_LSB = 0;
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;
  function automatic logic sign_ext_op(input logic [3:0] op);
    return op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE};
  endfunction
endpackage

// File: rtl/ir_opdecode.sv
// ir_opdecode: opcode -> extender mode; IR_ILLEGAL_TRAP_EN adds illegal-opcode flag for 0xC..0xF
module ir_opdecode
  import ir_fetch_decode_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       extop
`ifdef IR_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);
`ifdef IR_ILLEGAL_TRAP_EN
  assign illegal_op = opcode[3] & opcode[2];
  assign extop = sign_ext_op(opcode) & ~illegal_op;
`else
  assign extop = sign_ext_op(opcode);
`endif
endmodule

// File: rtl/ir_fetch_decode.sv
// ir_fetch_decode: instruction fetch FSM with timeout and IR field decode; IR_ILLEGAL_TRAP_EN adds illegal output
module ir_fetch_decode
  import ir_fetch_decode_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic [15:0] pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        ir_valid,
  output logic [15:0] ir_out,
  output logic [3:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [7:0]  imm8,
  output logic        extop,
  output logic        busy,
  output logic        fetch_err
`ifdef IR_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  state_t state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [15:0] addr_d, ir_d;
  logic err_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      imem_addr <= '0;
      ir_out    <= '0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      imem_addr <= addr_d;
      ir_out    <= ir_d;
      fetch_err <= err_d;
    end
  // ack is tested before the timeout so a coincident ack counts as success
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = imem_addr;
    ir_d    = ir_out;
    err_d   = fetch_err;
    if (state != REQ && fetch_start) begin
      state_d = REQ;
      cnt_d   = '0;
      addr_d  = pc;
      err_d   = 1'b0;
    end else if (state == REQ) begin
      if (imem_ack) begin
        state_d = HOLD;
        ir_d    = imem_rdata;
      end else if (cnt == TO_LAST) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else cnt_d = cnt + 8'd1;
    end
  end
  assign imem_req = state == REQ;
  assign busy     = state == REQ;
  assign ir_valid = state == HOLD;
  assign opcode   = ir_out[OP_LSB +: FIELD_W];
  assign rd       = ir_out[RD_LSB +: FIELD_W];
  assign rs       = ir_out[RS_LSB +: FIELD_W];
  assign rt       = ir_out[RT_LSB +: FIELD_W];
  assign imm8     = ir_out[IMM_LSB +: IMM_W];
`ifdef IR_ILLEGAL_TRAP_EN
  logic illegal_op;
  ir_opdecode u_dec (.opcode(opcode), .extop(extop), .illegal_op(illegal_op));
  assign illegal = ir_valid & illegal_op;
`else
  ir_opdecode u_dec (.opcode(opcode), .extop(extop));
`endif
endmodule
